// File: rtl/seg_pkg.sv
// Purpose : shared constants for the hex 7-segment scan display (decode table, off patterns).
// Latency : n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   NUM_DIGITS / DIG_W : digit count and digit-index width
//   SEG_OFF / AN_OFF   : all-segments-off and all-anodes-off patterns (active low)
//   HEX_SEG            : 16-entry nibble -> {g,f,e,d,c,b,a} table, active low
//   an_for_digit()     : one-hot-low anode pattern for a digit index
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Drive a low on the selected digit's anode only.
    function automatic logic [3:0] an_for_digit(input logic [DIG_W-1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose : combinational hex nibble to 7-segment (active-low) decoder.
// Latency : 0 cycles (pure lookup).
// Backpressure: none; output follows input.
//
// Ports:
//   nib : 4-bit hex digit in
//   seg : {g,f,e,d,c,b,a} out, active low
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/hex4_seg_scan.sv
// Purpose : time-multiplexes a 16-bit value as four hex digits on a common-anode 7-segment display.
// Latency : outputs registered, 1 cycle from scan state; value reaches the display on the frame after it is sampled.
// Backpressure: none; hold=1 freezes the frame snapshot, scanning never stalls.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   value      : 16-bit value to show, value[3:0] is digit 0 (rightmost)
//   hold       : 1 keeps the current snapshot at the frame boundary
//   seg        : segments {g,f,e,d,c,b,a}, active low
//   dp         : decimal point, active low, always off
//   an         : digit anodes, active low one-hot, an[0] is digit 0
//   frame_tick : one-cycle pulse during the blank cycle of each digit-0 slot
module hex4_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        hold,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int             PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

    // Scan position of the cycle whose outputs are produced at the next edge.
    logic [PW-1:0]    pre;
    logic [DIG_W-1:0] dig;
    logic [15:0]      snap;

    logic             pre_wrap;
    logic             frame_end;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;
    logic             lz_blank;
    logic             blank_cyc;

    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;
    logic             tick_nxt;

    assign pre_wrap  = (pre == PRE_LAST);
    assign frame_end = pre_wrap && (dig == DIG_W'(NUM_DIGITS - 1));
    assign blank_cyc = (pre == '0);

    always_comb begin
        cur_nib = snap[3:0];
        case (dig)
            2'd0: cur_nib = snap[3:0];
            2'd1: cur_nib = snap[7:4];
            2'd2: cur_nib = snap[11:8];
            2'd3: cur_nib = snap[15:12];
            default: cur_nib = snap[3:0];
        endcase
    end

    hex_to_seg7 u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    // A digit above 0 is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz_blank = 1'b0;
        if (BLANK_LZ) begin
            case (dig)
                2'd1: lz_blank = (snap[15:4]  == 12'h000);
                2'd2: lz_blank = (snap[15:8]  == 8'h00);
                2'd3: lz_blank = (snap[15:12] == 4'h0);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    // Pre-slot blank cycle keeps adjacent digits from ghosting into each other.
    always_comb begin
        an_nxt   = AN_OFF;
        seg_nxt  = SEG_OFF;
        tick_nxt = blank_cyc && (dig == '0);
        if (!blank_cyc && !lz_blank) begin
            an_nxt  = an_for_digit(dig);
            seg_nxt = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            dig        <= '0;
            snap       <= 16'h0000;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            pre <= pre_wrap ? '0 : pre + PRE_ONE;
            if (pre_wrap) begin
                dig <= dig + DIG_W'(1);
            end
            // Snapshot only at the frame boundary so a frame never mixes old and new nibbles.
            if (frame_end && !hold) begin
                snap <= value;
            end
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= 1'b1;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_hex4_seg_scan.sv
module tb_hex4_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [15:0] value;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        ft0, ft1;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    hex4_seg_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .hold       (hold),
        .seg        (seg0),
        .dp         (dp0),
        .an         (an0),
        .frame_tick (ft0)
    );

    hex4_seg_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_lz (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .hold       (hold),
        .seg        (seg1),
        .dp         (dp1),
        .an         (an1),
        .frame_tick (ft1)
    );

    // Compared word is {an, seg, dp, frame_tick}.
    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed={an=%b seg=%b dp=%b ft=%b} expected={an=%b seg=%b dp=%b ft=%b}",
                   tag, obs[12:9], obs[8:2], obs[1], obs[0],
                   exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // c is the cycle index within a frame (0..15), snap the expected displayed snapshot.
    task automatic check_cycle(input int c, input logic [15:0] snap, input string tag);
        int          slot;
        int          w;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_ft;
        logic        lz;
        slot  = c / 4;
        w     = c % 4;
        upper = snap >> (4 * slot);
        nib   = upper[3:0];
        e_ft  = (w == 0) && (slot == 0);
        if (w == 0) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end else begin
            e_an  = ~(4'b0001 << slot);
            e_seg = TBL[nib];
        end
        chk($sformatf("%s_c%0d", tag, c), {an0, seg0, dp0, ft0}, {e_an, e_seg, 1'b1, e_ft});
        lz = (slot != 0) && (upper == 16'h0000);
        if (lz) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end
        chk($sformatf("%s_lz_c%0d", tag, c), {an1, seg1, dp1, ft1}, {e_an, e_seg, 1'b1, e_ft});
    endtask

    // Runs one full frame; new value/hold are applied mid-slot-0, far from the snapshot edge.
    task automatic run_frame(input logic [15:0] snap, input logic [15:0] nv, input logic nh,
                             input bit scramble, input bit glitch, input string tag);
        for (int c = 0; c < 16; c++) begin
            step();
            if (scramble) value = 16'($urandom);
            check_cycle(c, snap, tag);
            if (c == 2) begin
                value = nv;
                hold  = nh;
            end
            // Short reset pulse wholly between edges, inside the digit-2 slot.
            if (glitch && c == 9) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        value = 16'h1234;

        step();
        chk("rst_e1",    {an0, seg0, dp0, ft0}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        chk("rst_e1_lz", {an1, seg1, dp1, ft1}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        step();
        chk("rst_e2",    {an0, seg0, dp0, ft0}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        chk("rst_e2_lz", {an1, seg1, dp1, ft1}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        rst = 1'b0;

        run_frame(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, "f0_zero");
        run_frame(16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, "f1_1234");
        run_frame(16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0, "f2_abcd");
        run_frame(16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, "f3_hold_on");
        run_frame(16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, "f4_held");
        run_frame(16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, "f5_held");
        run_frame(16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, "f6_held");
        run_frame(16'hBEEF, 16'h0050, 1'b0, 1'b0, 1'b0, "f7_beef");
        run_frame(16'h0050, 16'h0000, 1'b0, 1'b0, 1'b0, "f8_0050");
        run_frame(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, "f9_0000");
        run_frame(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, "f10_glitch");

        for (int c = 0; c < 6; c++) begin
            step();
            check_cycle(c, 16'h1234, "f11_pre");
        end
        rst = 1'b1;
        step();
        chk("midrst",    {an0, seg0, dp0, ft0}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        chk("midrst_lz", {an1, seg1, dp1, ft1}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        rst = 1'b0;

        run_frame(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, "f12_after_rst");
        run_frame(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, "f13_1234");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
